// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// decoder
//   Combinational instruction decoder that decode_queue instantiates once.
//   Field layout of a 32-bit instruction word:
//     [7:0]   opcode
//     [11:8]  rde   destination register
//     [15:12] rs1   source register 1
//     [19:16] rs2   source register 2
//     [23:20] func  function field
//     [31:8]  imm   immediate (overlaps the register fields)
//   The format code is taken from opcode[6:4].
// Ports: instr in; opcode, rde, rs1, rs2, func, imm, itype out.
// ---------------------------------------------------------------------------
module decoder (
  input  logic [31:0] instr,
  output logic [7:0]  opcode,
  output logic [3:0]  rde,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  func,
  output logic [23:0] imm,
  output logic [2:0]  itype
);
  assign opcode = instr[7:0];
  assign rde    = instr[11:8];
  assign rs1    = instr[15:12];
  assign rs2    = instr[19:16];
  assign func   = instr[23:20];
  assign imm    = instr[31:8];
  assign itype  = instr[6:4];
endmodule

// ---------------------------------------------------------------------------
// decode_queue
//   Buffered decode stage between fetch and issue. Each accepted word is
//   decoded at push time and stored with its PC in a DEPTH-entry circular
//   queue; the head entry is presented to issue from registers only.
// Ports:
//   clk, rst (sync, active-high), flush (drop all entries)
//   in_valid/in_ready/in_instr/in_pc      : fetch-side handshake
//   out_valid/out_ready/out_*             : issue-side handshake, head fields
//   count                                 : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_opcode,
  output logic [3:0]       out_rde,
  output logic [3:0]       out_rs1,
  output logic [3:0]       out_rs2,
  output logic [3:0]       out_func,
  output logic [23:0]      out_imm,
  output logic [2:0]       out_type,
  output logic [PC_W-1:0]  out_pc,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [7:0]      opcode;
    logic [3:0]      rde;
    logic [3:0]      rs1;
    logic [3:0]      rs2;
    logic [3:0]      func;
    logic [23:0]     imm;
    logic [2:0]      itype;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           new_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  decoder u_decoder (
    .instr  (in_instr),
    .opcode (new_entry.opcode),
    .rde    (new_entry.rde),
    .rs1    (new_entry.rs1),
    .rs2    (new_entry.rs2),
    .func   (new_entry.func),
    .imm    (new_entry.imm),
    .itype  (new_entry.itype)
  );
  assign new_entry.pc = in_pc;

  // Handshake flags depend on registered count only, so no in_* -> out_* path.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are log2(DEPTH) bits, so the increment wraps modulo DEPTH.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_opcode = head.opcode;
  assign out_rde    = head.rde;
  assign out_rs1    = head.rs1;
  assign out_rs2    = head.rs2;
  assign out_func   = head.func;
  assign out_imm    = head.imm;
  assign out_type   = head.itype;
  assign out_pc     = head.pc;
  assign count      = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_decode_queue
//   Directed bench for decode_queue (DEPTH=4, PC_W=32). Inputs change 1ns
//   after a rising edge; outputs are sampled at the same point, reflecting
//   the state left by that edge.
// ---------------------------------------------------------------------------
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc, out_pc;
  logic [7:0]       out_opcode;
  logic [3:0]       out_rde, out_rs1, out_rs2, out_func;
  logic [23:0]      out_imm;
  logic [2:0]       out_type;
  logic [CNT_W-1:0] count;

  int checks   = 0;
  int failures = 0;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_rde    (out_rde),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_func   (out_func),
    .out_imm    (out_imm),
    .out_type   (out_type),
    .out_pc     (out_pc),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++;
    if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_push_hold();
    do_reset();
    push_one(32'h00000401, 32'h100);
    checks++;
    if (count !== 3'd1) begin failures++; $display("FAIL push1_count got=%0d exp=1", count); end
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL push1_valid got=%b exp=1", out_valid); end
    push_one(32'h20011410, 32'h104);
    checks++;
    if (count !== 3'd2) begin failures++; $display("FAIL push2_count got=%0d exp=2", count); end
    // Hold the head with out_ready=0 for a few cycles and re-check every field.
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({out_opcode, out_rde, out_rs1, out_rs2, out_func, out_imm, out_type, out_pc} !==
          {8'h01, 4'h4, 4'h0, 4'h0, 4'h0, 24'h000004, 3'd0, 32'h100}) begin
        failures++;
        $display("FAIL head_hold cyc=%0d got op=%h rde=%h rs1=%h rs2=%h func=%h imm=%h type=%0d pc=%h exp op=01 rde=4 rs1=0 rs2=0 func=0 imm=000004 type=0 pc=100",
                 c, out_opcode, out_rde, out_rs1, out_rs2, out_func, out_imm, out_type, out_pc);
      end
      step();
    end
    // Pop the first entry; second word's decoded fields appear at the head.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({out_opcode, out_rde, out_rs1, out_rs2, out_func, out_imm, out_type, out_pc} !==
        {8'h10, 4'h4, 4'h1, 4'h1, 4'h0, 24'h200114, 3'd1, 32'h104}) begin
      failures++;
      $display("FAIL head_second got op=%h rde=%h rs1=%h rs2=%h func=%h imm=%h type=%0d pc=%h exp op=10 rde=4 rs1=1 rs2=1 func=0 imm=200114 type=1 pc=104",
               out_opcode, out_rde, out_rs1, out_rs2, out_func, out_imm, out_type, out_pc);
    end
  endtask

  task automatic test_fill_drain();
    logic [PC_W-1:0] exp_pc;
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_one(32'h00000001 + 32'(i), 32'h100 + 32'(4 * i));
    checks++;
    if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    push_one(32'hDEADBE77, 32'h110);
    checks++;
    if (count !== 3'd4) begin failures++; $display("FAIL fifth_push_count got=%0d exp=4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_pc = 32'h100 + 32'(4 * i);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
        failures++;
        $display("FAIL drain_pc idx=%0d got valid=%b pc=%h exp valid=1 pc=%h", i, out_valid, out_pc, exp_pc);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      failures++;
      $display("FAIL drain_empty got valid=%b count=%0d exp valid=0 count=0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr    = (i == 5) ? 32'h5432FF13 : {24'h0, 8'(8'h20 + i)};
      pc       = 32'h200 + 32'(4 * i);
      in_instr = instr;
      in_pc    = pc;
      step();
      checks++;
      if (count !== 3'd1 || out_valid !== 1'b1 || out_pc !== pc || out_opcode !== instr[7:0]) begin
        failures++;
        $display("FAIL stream idx=%0d got count=%0d valid=%b pc=%h op=%h exp count=1 valid=1 pc=%h op=%h",
                 i, count, out_valid, out_pc, out_opcode, pc, instr[7:0]);
      end
      if (i == 5) begin
        checks++;
        if ({out_opcode, out_rde, out_rs1, out_rs2, out_func, out_imm, out_type} !==
            {8'h13, 4'hF, 4'hF, 4'h2, 4'h3, 24'h5432FF, 3'd1}) begin
          failures++;
          $display("FAIL stream_5432ff13 got op=%h rde=%h rs1=%h rs2=%h func=%h imm=%h type=%0d exp op=13 rde=f rs1=f rs2=2 func=3 imm=5432ff type=1",
                   out_opcode, out_rde, out_rs1, out_rs2, out_func, out_imm, out_type);
        end
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_end got count=%0d valid=%b exp count=0 valid=0", count, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) push_one(32'h00000031 + 32'(i), 32'h300 + 32'(4 * i));
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00000099; in_pc = 32'h30C; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_state got count=%0d valid=%b ready=%b exp count=0 valid=0 ready=1", count, out_valid, in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_quiet cyc=%0d got valid=%b exp=0", c, out_valid); end
    end
    out_ready = 1'b0;
    push_one(32'h00000042, 32'h400);
    checks++;
    if (count !== 3'd1 || out_pc !== 32'h400 || out_opcode !== 8'h42) begin
      failures++;
      $display("FAIL flush_restart got count=%0d pc=%h op=%h exp count=1 pc=400 op=42", count, out_pc, out_opcode);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    push_one(32'h00000051, 32'h500);
    push_one(32'h00000052, 32'h504);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00000053; in_pc = 32'h508;
    step();
    idle_inputs();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid got count=%0d valid=%b ready=%b exp count=0 valid=0 ready=1", count, out_valid, in_ready);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_push_hold();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
